dual_port_ram_ctrl: RTL and testbench
=====================================

// Module: dual_port_ram_ctrl
// PURPOSE
//  Parametrised single-clock true dual-port RAM, successor to dual_port_RAM. Two independent
//  read/write ports (A, B) with byte enables, write-write collision arbitration, selectable
//  read-during-write behaviour, optional output register and a post-reset memory-clear sequencer.
//  Shared scratch/buffer memory between two masters in the same clock domain.
// PARAMETERS
//  DATA_W    16   data width per port; must be a multiple of 8
//  ADDR_W    4    address width; DEPTH = 2**ADDR_W words
//  OUT_REG   0    0: read latency 1 cycle; 1: extra output register, latency 2
//  RDW_MODE  0    cross-port read of address written same cycle: 0 old data, 1 new (merged) data
//  PRIORITY  0    write-write collision winner: 0 port A, 1 port B
//  INIT_CLR  1    1: clear all words to 0 after reset; 0: ready immediately after reset
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         asynchronous, active-high reset
//  enA/enB    in   1         port request enable
//  wrA/wrB    in   1         1 write, 0 read (qualified by en)
//  beA/beB    in   DATA_W/8  byte enables for writes (bit i -> din[8i+7:8i])
//  addA/addB  in   ADDR_W    word address
//  dinA/dinB  in   DATA_W    write data
//  doutA/doutB out DATA_W    read data
//  vldA/vldB  out  1         one-cycle pulse: dout carries data for a completed read
//  ready      out  1         1 when the RAM accepts requests
//  collision  out  1         one-cycle pulse: write-write collision occurred
//  coll_cnt   out  16        saturating count of write-write collisions
// BEHAVIOUR
//  - Reset (async assert): doutA/B=0, vldA/B=0, collision=0, coll_cnt=0, ready=0, FSM->INIT
//    (INIT_CLR=1) or READY (INIT_CLR=0, ready=1 one cycle after rst release). rst does not clear
//    memory array directly.
//  - FSM INIT: clear pointer starts at 0, writes 0 to one word per cycle; after word DEPTH-1 -> READY,
//    ready=1 on the following cycle (exactly DEPTH cycles of ready=0 after rst deassert).
//    All port requests during INIT ignored: no write, no vld. rst during INIT restarts from word 0.
//  - FSM READY: stays until rst. Per port, en&wr: write bytes with be=1 at add on the rising edge;
//    en&!wr: read add. en=0: idle.
//  - Read latency: OUT_REG=0 -> dout/vld valid the cycle after request; OUT_REG=1 -> two cycles.
//    dout holds last read value when no read completes; writes never update own-port dout or vld.
//  - Back-to-back reads on every cycle sustained on both ports (throughput 1/cycle/port).
//  - Write-write same address: per byte, winner's byte if winner be set, else loser's byte if loser
//    be set. Counts as collision whenever addA==addB and both en&wr, regardless of be overlap.
//    collision pulses the cycle after; coll_cnt increments, saturates at 16'hFFFF.
//  - Read on one port, write on other, same address: reader gets pre-write word (RDW_MODE=0) or
//    post-write merged word (RDW_MODE=1). Not a collision.
//  - Read-read same address: both ports return the word; not a collision.
//  - Address wraps naturally within DEPTH (no out-of-range possible).
// TESTING (defaults unless stated)
//  1 rst 1->0, hold: ready=0 for exactly 16 cycles then 1; read A addr 5 -> doutA=16'h0000, vldA pulse.
//  2 A write 16'h4B4F addr1 be=2'b11; next cycle B read addr1 -> next cycle doutB=16'h4B4F, vldB=1 one cycle.
//  3 A write 16'hFFFF addr2; then beA=2'b01 din 16'h1234 addr2; read -> 16'hFF34.
//  4 A 16'hAAAA, B 16'h5555 addr3 both be=11 -> word 16'hAAAA, collision pulse, coll_cnt=1;
//    PRIORITY=1 -> 16'h5555; beA=10, beB=01 -> 16'hAA55, coll_cnt=2.
//  5 addr4=16'h2222; A writes 16'h1111 while B reads addr4: RDW_MODE=0 -> doutB=16'h2222; RDW_MODE=1 -> 16'h1111.
//  6 rst pulse at INIT cycle 7 -> ready stays 0, clear restarts, ready after 16 more cycles;
//    OUT_REG=1: read addr1 -> doutA/vldA two cycles after request; coll_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/dual_port_ram_ctrl.sv
// -----------------------------------------------------------------------------
// dual_port_ram_ctrl
//   Single-clock true dual-port RAM shared by two masters. Each port can read
//   or write one word per cycle with byte enables. Same-address writes from
//   both ports in one cycle are merged byte by byte, with the configured
//   winner taking precedence. A read on one port that hits the address being
//   written by the other port returns either the old word or the merged new
//   word. After reset an optional sequencer clears every word to zero before
//   the RAM starts accepting requests.
//
// Parameters
//   DATA_W   data width per port (multiple of 8)
//   ADDR_W   address width, DEPTH = 2**ADDR_W words
//   OUT_REG  0: read latency 1 cycle, 1: read latency 2 cycles
//   RDW_MODE cross-port read of a word written the same cycle:
//            0 returns old data, 1 returns the merged new data
//   PRIORITY write-write collision winner: 0 port A, 1 port B
//   INIT_CLR 1: clear the array after reset, 0: ready right after reset
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   enA/enB             port request enable
//   wrA/wrB             1 write, 0 read (qualified by en)
//   beA/beB             byte enables for writes
//   addA/addB           word address
//   dinA/dinB           write data
//   doutA/doutB         read data, holds the last completed read
//   vldA/vldB           one-cycle pulse when dout carries a completed read
//   ready               1 while requests are accepted
//   collision           one-cycle pulse after a write-write collision
//   coll_cnt            saturating count of write-write collisions
// -----------------------------------------------------------------------------
module dual_port_ram_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0,
  parameter int PRIORITY = 0,
  parameter int INIT_CLR = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enA,
  input  logic                wrA,
  input  logic [DATA_W/8-1:0] beA,
  input  logic [ADDR_W-1:0]   addA,
  input  logic [DATA_W-1:0]   dinA,
  input  logic                enB,
  input  logic                wrB,
  input  logic [DATA_W/8-1:0] beB,
  input  logic [ADDR_W-1:0]   addB,
  input  logic [DATA_W-1:0]   dinB,
  output logic [DATA_W-1:0]   doutA,
  output logic [DATA_W-1:0]   doutB,
  output logic                vldA,
  output logic                vldB,
  output logic                ready,
  output logic                collision,
  output logic [15:0]         coll_cnt
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Overlay the bytes of din selected by be onto base.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] base,
    input logic [DATA_W-1:0] din,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] res;
    res = base;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = din[8*i +: 8];
      end else begin
        res[8*i +: 8] = base[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              ready_q, ready_d;

  logic              pipe_vld_a_q, pipe_vld_a_d;
  logic              pipe_vld_b_q, pipe_vld_b_d;
  logic [DATA_W-1:0] pipe_data_a_q, pipe_data_a_d;
  logic [DATA_W-1:0] pipe_data_b_q, pipe_data_b_d;

  logic              vld_a_q, vld_a_d;
  logic              vld_b_q, vld_b_d;
  logic [DATA_W-1:0] dout_a_q, dout_a_d;
  logic [DATA_W-1:0] dout_b_q, dout_b_d;

  logic              collision_q, collision_d;
  logic [15:0]       coll_cnt_q, coll_cnt_d;

  logic              accept_s;
  logic              wr_a_s, wr_b_s, rd_a_s, rd_b_s;
  logic              same_addr_s, coll_s;
  logic [DATA_W-1:0] old_a_s, old_b_s;
  logic [DATA_W-1:0] word_a_s, word_b_s, coll_word_s;
  logic [DATA_W-1:0] rdata_a_s, rdata_b_s;
  logic              fin_vld_a_s, fin_vld_b_s;
  logic [DATA_W-1:0] fin_data_a_s, fin_data_b_s;

  // Request decode, write merging and read-data selection.
  always_comb begin
    accept_s    = (state_q == ST_READY);
    wr_a_s      = accept_s & enA & wrA;
    wr_b_s      = accept_s & enB & wrB;
    rd_a_s      = accept_s & enA & ~wrA;
    rd_b_s      = accept_s & enB & ~wrB;
    same_addr_s = (addA == addB);
    coll_s      = wr_a_s & wr_b_s & same_addr_s;

    old_a_s  = mem[addA];
    old_b_s  = mem[addB];
    word_a_s = merge_bytes(old_a_s, dinA, beA);
    word_b_s = merge_bytes(old_b_s, dinB, beB);

    // Loser's bytes go down first, winner's bytes are laid over them, so a
    // byte only the loser enables still lands.
    if (PRIORITY != 0) begin
      coll_word_s = merge_bytes(word_a_s, dinB, beB);
    end else begin
      coll_word_s = merge_bytes(word_b_s, dinA, beA);
    end

    // A reading port can only collide with a write from the other port.
    if ((RDW_MODE != 0) && wr_b_s && same_addr_s) begin
      rdata_a_s = word_b_s;
    end else begin
      rdata_a_s = old_a_s;
    end
    if ((RDW_MODE != 0) && wr_a_s && same_addr_s) begin
      rdata_b_s = word_a_s;
    end else begin
      rdata_b_s = old_b_s;
    end
  end

  // Next-state for the clear sequencer, read pipeline and collision tracking.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_INIT: begin
        if (clr_ptr_q == {ADDR_W{1'b1}}) begin
          state_d   = ST_READY;
          clr_ptr_d = {ADDR_W{1'b0}};
        end else begin
          state_d   = ST_INIT;
          clr_ptr_d = clr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d   = ST_INIT;
        clr_ptr_d = {ADDR_W{1'b0}};
      end
    endcase
    // ready follows the state one cycle late so it rises after the last clear.
    ready_d = (state_d == ST_READY);

    pipe_vld_a_d = rd_a_s;
    pipe_vld_b_d = rd_b_s;
    if (rd_a_s) begin
      pipe_data_a_d = rdata_a_s;
    end else begin
      pipe_data_a_d = pipe_data_a_q;
    end
    if (rd_b_s) begin
      pipe_data_b_d = rdata_b_s;
    end else begin
      pipe_data_b_d = pipe_data_b_q;
    end

    if (OUT_REG != 0) begin
      fin_vld_a_s  = pipe_vld_a_q;
      fin_vld_b_s  = pipe_vld_b_q;
      fin_data_a_s = pipe_data_a_q;
      fin_data_b_s = pipe_data_b_q;
    end else begin
      fin_vld_a_s  = rd_a_s;
      fin_vld_b_s  = rd_b_s;
      fin_data_a_s = rdata_a_s;
      fin_data_b_s = rdata_b_s;
    end

    vld_a_d = fin_vld_a_s;
    vld_b_d = fin_vld_b_s;
    // dout only moves when a read completes; writes leave it alone.
    if (fin_vld_a_s) begin
      dout_a_d = fin_data_a_s;
    end else begin
      dout_a_d = dout_a_q;
    end
    if (fin_vld_b_s) begin
      dout_b_d = fin_data_b_s;
    end else begin
      dout_b_d = dout_b_q;
    end

    collision_d = coll_s;
    if (coll_s && (coll_cnt_q != 16'hFFFF)) begin
      coll_cnt_d = coll_cnt_q + 16'd1;
    end else begin
      coll_cnt_d = coll_cnt_q;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= (INIT_CLR != 0) ? ST_INIT : ST_READY;
      clr_ptr_q     <= {ADDR_W{1'b0}};
      ready_q       <= 1'b0;
      pipe_vld_a_q  <= 1'b0;
      pipe_vld_b_q  <= 1'b0;
      pipe_data_a_q <= {DATA_W{1'b0}};
      pipe_data_b_q <= {DATA_W{1'b0}};
      vld_a_q       <= 1'b0;
      vld_b_q       <= 1'b0;
      dout_a_q      <= {DATA_W{1'b0}};
      dout_b_q      <= {DATA_W{1'b0}};
      collision_q   <= 1'b0;
      coll_cnt_q    <= 16'h0000;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      ready_q       <= ready_d;
      pipe_vld_a_q  <= pipe_vld_a_d;
      pipe_vld_b_q  <= pipe_vld_b_d;
      pipe_data_a_q <= pipe_data_a_d;
      pipe_data_b_q <= pipe_data_b_d;
      vld_a_q       <= vld_a_d;
      vld_b_q       <= vld_b_d;
      dout_a_q      <= dout_a_d;
      dout_b_q      <= dout_b_d;
      collision_q   <= collision_d;
      coll_cnt_q    <= coll_cnt_d;
    end
  end

  // Storage array: clear sweep during INIT, otherwise port writes.
  always_ff @(posedge clk) begin
    if ((state_q == ST_INIT) && !rst) begin
      mem[clr_ptr_q] <= {DATA_W{1'b0}};
    end else if (coll_s) begin
      mem[addA] <= coll_word_s;
    end else begin
      if (wr_a_s) begin
        mem[addA] <= word_a_s;
      end
      if (wr_b_s) begin
        mem[addB] <= word_b_s;
      end
    end
  end

  assign doutA     = dout_a_q;
  assign doutB     = dout_b_q;
  assign vldA      = vld_a_q;
  assign vldB      = vld_b_q;
  assign ready     = ready_q;
  assign collision = collision_q;
  assign coll_cnt  = coll_cnt_q;

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Bench for dual_port_ram_ctrl. Three instances share one stimulus stream:
//   d0: defaults (OUT_REG=0, RDW_MODE=0, PRIORITY=0, INIT_CLR=1)
//   d1: RDW_MODE=1, PRIORITY=1, INIT_CLR=0
//   d2: OUT_REG=1, otherwise defaults (its read outputs trail d0 by one cycle)
module tb_dual_port_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enA, wrA, enB, wrB;
  logic [1:0]  beA, beB;
  logic [3:0]  addA, addB;
  logic [15:0] dinA, dinB;

  logic [15:0] doutA0, doutB0, cnt0, doutA1, doutB1, cnt1, doutA2, doutB2, cnt2;
  logic        vldA0, vldB0, rdy0, col0;
  logic        vldA1, vldB1, rdy1, col1;
  logic        vldA2, vldB2, rdy2, col2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dual_port_ram_ctrl #(.DATA_W(16), .ADDR_W(4), .OUT_REG(0), .RDW_MODE(0), .PRIORITY(0), .INIT_CLR(1)) u_d0 (
    .clk(clk), .rst(rst), .enA(enA), .wrA(wrA), .beA(beA), .addA(addA), .dinA(dinA),
    .enB(enB), .wrB(wrB), .beB(beB), .addB(addB), .dinB(dinB),
    .doutA(doutA0), .doutB(doutB0), .vldA(vldA0), .vldB(vldB0),
    .ready(rdy0), .collision(col0), .coll_cnt(cnt0));

  dual_port_ram_ctrl #(.DATA_W(16), .ADDR_W(4), .OUT_REG(0), .RDW_MODE(1), .PRIORITY(1), .INIT_CLR(0)) u_d1 (
    .clk(clk), .rst(rst), .enA(enA), .wrA(wrA), .beA(beA), .addA(addA), .dinA(dinA),
    .enB(enB), .wrB(wrB), .beB(beB), .addB(addB), .dinB(dinB),
    .doutA(doutA1), .doutB(doutB1), .vldA(vldA1), .vldB(vldB1),
    .ready(rdy1), .collision(col1), .coll_cnt(cnt1));

  dual_port_ram_ctrl #(.DATA_W(16), .ADDR_W(4), .OUT_REG(1), .RDW_MODE(0), .PRIORITY(0), .INIT_CLR(1)) u_d2 (
    .clk(clk), .rst(rst), .enA(enA), .wrA(wrA), .beA(beA), .addA(addA), .dinA(dinA),
    .enB(enB), .wrB(wrB), .beB(beB), .addB(addB), .dinB(dinB),
    .doutA(doutA2), .doutB(doutB2), .vldA(vldA2), .vldB(vldB2),
    .ready(rdy2), .collision(col2), .coll_cnt(cnt2));

  typedef struct {
    logic        ea, wa;
    logic [1:0]  ba;
    logic [3:0]  aa;
    logic [15:0] da;
    logic        eb, wb;
    logic [1:0]  bb;
    logic [3:0]  ab;
    logic [15:0] db;
    logic        xva;
    logic [15:0] xda;
    logic        xvb;
    logic [15:0] xdb;
    logic        xc;
    logic [15:0] xn;
    logic [15:0] x1a, x1b;
    logic        k1;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(
    input logic ea, input logic wa, input logic [1:0] ba, input logic [3:0] aa, input logic [15:0] da,
    input logic eb, input logic wb, input logic [1:0] bb, input logic [3:0] ab, input logic [15:0] db,
    input logic xva, input logic [15:0] xda, input logic xvb, input logic [15:0] xdb,
    input logic xc, input logic [15:0] xn, input logic [15:0] x1a, input logic [15:0] x1b,
    input logic k1);
    vec_t v;
    v.ea = ea; v.wa = wa; v.ba = ba; v.aa = aa; v.da = da;
    v.eb = eb; v.wb = wb; v.bb = bb; v.ab = ab; v.db = db;
    v.xva = xva; v.xda = xda; v.xvb = xvb; v.xdb = xdb;
    v.xc = xc; v.xn = xn; v.x1a = x1a; v.x1b = x1b; v.k1 = k1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    enA = 1'b0; wrA = 1'b0; beA = 2'b00; addA = 4'd0; dinA = 16'h0000;
    enB = 1'b0; wrB = 1'b0; beB = 2'b00; addB = 4'd0; dinB = 16'h0000;
  endtask

  // Counts rising edges until d0 reports ready; also flags any read pulse.
  task automatic wait_ready(output int n, output logic saw_vld);
    n = 0;
    saw_vld = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      n++;
      if (vldA0 || vldB0 || vldA2 || vldB2) saw_vld = 1'b1;
      if (rdy0) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic sv;
    logic pva, pvb;
    logic [15:0] pda, pdb;

    vecs[0]  = mk(1,0,2'b00,4'd5,16'h0000, 0,0,2'b00,4'd0,16'h0000, 1,16'h0000, 0,16'h0000, 0,16'd0, 16'h0000,16'h0000, 0);
    vecs[1]  = mk(1,1,2'b11,4'd1,16'h4B4F, 0,0,2'b00,4'd0,16'h0000, 0,16'h0000, 0,16'h0000, 0,16'd0, 16'h0000,16'h0000, 1);
    vecs[2]  = mk(0,0,2'b00,4'd0,16'h0000, 1,0,2'b00,4'd1,16'h0000, 0,16'h0000, 1,16'h4B4F, 0,16'd0, 16'h0000,16'h4B4F, 1);
    vecs[3]  = mk(0,0,2'b00,4'd0,16'h0000, 0,0,2'b00,4'd0,16'h0000, 0,16'h0000, 0,16'h4B4F, 0,16'd0, 16'h0000,16'h0000, 1);
    vecs[4]  = mk(1,1,2'b11,4'd2,16'hFFFF, 0,0,2'b00,4'd0,16'h0000, 0,16'h0000, 0,16'h4B4F, 0,16'd0, 16'h0000,16'h0000, 1);
    vecs[5]  = mk(1,1,2'b01,4'd2,16'h1234, 0,0,2'b00,4'd0,16'h0000, 0,16'h0000, 0,16'h4B4F, 0,16'd0, 16'h0000,16'h0000, 1);
    vecs[6]  = mk(1,0,2'b00,4'd2,16'h0000, 0,0,2'b00,4'd0,16'h0000, 1,16'hFF34, 0,16'h4B4F, 0,16'd0, 16'hFF34,16'h0000, 1);
    vecs[7]  = mk(1,1,2'b11,4'd3,16'hAAAA, 1,1,2'b11,4'd3,16'h5555, 0,16'hFF34, 0,16'h4B4F, 1,16'd1, 16'h0000,16'h0000, 1);
    vecs[8]  = mk(1,0,2'b00,4'd3,16'h0000, 0,0,2'b00,4'd0,16'h0000, 1,16'hAAAA, 0,16'h4B4F, 0,16'd1, 16'h5555,16'h0000, 1);
    vecs[9]  = mk(1,1,2'b10,4'd3,16'hAAAA, 1,1,2'b01,4'd3,16'h5555, 0,16'hAAAA, 0,16'h4B4F, 1,16'd2, 16'h0000,16'h0000, 1);
    vecs[10] = mk(0,0,2'b00,4'd0,16'h0000, 1,0,2'b00,4'd3,16'h0000, 0,16'hAAAA, 1,16'hAA55, 0,16'd2, 16'h0000,16'hAA55, 1);
    vecs[11] = mk(1,1,2'b11,4'd4,16'h2222, 0,0,2'b00,4'd0,16'h0000, 0,16'hAAAA, 0,16'hAA55, 0,16'd2, 16'h0000,16'h0000, 1);
    vecs[12] = mk(1,1,2'b11,4'd4,16'h1111, 1,0,2'b00,4'd4,16'h0000, 0,16'hAAAA, 1,16'h2222, 0,16'd2, 16'h0000,16'h1111, 1);
    vecs[13] = mk(0,0,2'b00,4'd0,16'h0000, 1,0,2'b00,4'd4,16'h0000, 0,16'hAAAA, 1,16'h1111, 0,16'd2, 16'h0000,16'h1111, 1);
    vecs[14] = mk(1,0,2'b00,4'd4,16'h0000, 1,0,2'b00,4'd4,16'h0000, 1,16'h1111, 1,16'h1111, 0,16'd2, 16'h1111,16'h1111, 1);
    vecs[15] = mk(1,1,2'b00,4'd4,16'h0000, 1,1,2'b00,4'd4,16'h0000, 0,16'h1111, 0,16'h1111, 1,16'd3, 16'h0000,16'h0000, 1);
    vecs[16] = mk(1,0,2'b00,4'd4,16'h0000, 0,0,2'b00,4'd0,16'h0000, 1,16'h1111, 0,16'h1111, 0,16'd3, 16'h1111,16'h0000, 1);
    vecs[17] = mk(1,1,2'b11,4'd6,16'h6666, 1,1,2'b11,4'd7,16'h7777, 0,16'h1111, 0,16'h1111, 0,16'd3, 16'h0000,16'h0000, 1);
    vecs[18] = mk(1,0,2'b00,4'd7,16'h0000, 1,0,2'b00,4'd6,16'h0000, 1,16'h7777, 1,16'h6666, 0,16'd3, 16'h7777,16'h6666, 1);
    vecs[19] = mk(0,0,2'b00,4'd0,16'h0000, 0,0,2'b00,4'd0,16'h0000, 0,16'h7777, 0,16'h6666, 0,16'd3, 16'h0000,16'h0000, 1);

    // Reset state.
    idle();
    #2;
    chk("rst_d0_ready", {31'd0, rdy0}, 32'd0);
    chk("rst_d1_ready", {31'd0, rdy1}, 32'd0);
    chk("rst_d0_outs", {vldA0, vldB0, col0, doutA0[12:0]}, 16'h0000);
    chk("rst_d0_doutB", {16'd0, doutB0}, 32'd0);
    chk("rst_d0_cnt", {16'd0, cnt0}, 32'd0);
    chk("rst_d2_outs", {vldA2, vldB2, col2, 13'd0} | {16'd0} | 32'(doutA2 | doutB2 | cnt2), 32'd0);

    // Release reset and time the clear sequence.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("d1_ready_before_edge", {31'd0, rdy1}, 32'd0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk("d1_ready_one_cycle", {31'd0, rdy1}, 32'd1);
      if (rdy0) break;
    end
    chk("init_cycles_d0", n, 32'd16);
    chk("init_ready_d2", {31'd0, rdy2}, 32'd1);

    // Table-driven vectors.
    pva = 1'b0; pvb = 1'b0; pda = 16'h0000; pdb = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      enA = vecs[i].ea; wrA = vecs[i].wa; beA = vecs[i].ba; addA = vecs[i].aa; dinA = vecs[i].da;
      enB = vecs[i].eb; wrB = vecs[i].wb; beB = vecs[i].bb; addB = vecs[i].ab; dinB = vecs[i].db;
      @(posedge clk); #1;
      chk($sformatf("r%0d_d0_vldA", i), {31'd0, vldA0}, {31'd0, vecs[i].xva});
      chk($sformatf("r%0d_d0_doutA", i), {16'd0, doutA0}, {16'd0, vecs[i].xda});
      chk($sformatf("r%0d_d0_vldB", i), {31'd0, vldB0}, {31'd0, vecs[i].xvb});
      chk($sformatf("r%0d_d0_doutB", i), {16'd0, doutB0}, {16'd0, vecs[i].xdb});
      chk($sformatf("r%0d_d0_coll", i), {31'd0, col0}, {31'd0, vecs[i].xc});
      chk($sformatf("r%0d_d0_cnt", i), {16'd0, cnt0}, {16'd0, vecs[i].xn});
      chk($sformatf("r%0d_d1_vld", i), {30'd0, vldA1, vldB1}, {30'd0, vecs[i].xva, vecs[i].xvb});
      chk($sformatf("r%0d_d1_coll", i), {15'd0, col1, cnt1}, {15'd0, vecs[i].xc, vecs[i].xn});
      if (vecs[i].k1 && vecs[i].xva) chk($sformatf("r%0d_d1_doutA", i), {16'd0, doutA1}, {16'd0, vecs[i].x1a});
      if (vecs[i].k1 && vecs[i].xvb) chk($sformatf("r%0d_d1_doutB", i), {16'd0, doutB1}, {16'd0, vecs[i].x1b});
      chk($sformatf("r%0d_d2_A", i), {15'd0, vldA2, doutA2}, {15'd0, pva, pda});
      chk($sformatf("r%0d_d2_B", i), {15'd0, vldB2, doutB2}, {15'd0, pvb, pdb});
      chk($sformatf("r%0d_d2_coll", i), {15'd0, col2, cnt2}, {15'd0, vecs[i].xc, vecs[i].xn});
      pva = vecs[i].xva; pda = vecs[i].xda; pvb = vecs[i].xvb; pdb = vecs[i].xdb;
    end

    // Reset again, pulse reset at INIT cycle 7 while requests are pending.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    enA = 1'b1; wrA = 1'b0; addA = 4'd1;
    enB = 1'b1; wrB = 1'b1; beB = 2'b11; addB = 4'd0; dinB = 16'hBEEF;
    repeat (7) @(posedge clk);
    #1;
    chk("restart_ready_low_c7", {31'd0, rdy0}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    wait_ready(n, sv);
    idle();
    chk("restart_init_cycles", n, 32'd16);
    chk("init_no_vld", {31'd0, sv}, 32'd0);
    chk("restart_cnt_cleared", {16'd0, cnt0}, 32'd0);

    // Cleared words read back as zero; d2 answers one cycle later.
    @(negedge clk);
    enA = 1'b1; wrA = 1'b0; addA = 4'd1;
    enB = 1'b1; wrB = 1'b0; addB = 4'd0;
    @(posedge clk); #1;
    chk("clr_d0_A", {15'd0, vldA0, doutA0}, {15'd0, 1'b1, 16'h0000});
    chk("clr_d0_B", {15'd0, vldB0, doutB0}, {15'd0, 1'b1, 16'h0000});
    chk("oreg_d2_lat1", {30'd0, vldA2, vldB2}, 32'd0);
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    chk("oreg_d2_A", {15'd0, vldA2, doutA2}, {15'd0, 1'b1, 16'h0000});
    chk("oreg_d2_B", {15'd0, vldB2, doutB2}, {15'd0, 1'b1, 16'h0000});
    chk("clr_d0_vld_pulse", {30'd0, vldA0, vldB0}, 32'd0);

    // Collision counter saturation.
    @(negedge clk);
    enA = 1'b1; wrA = 1'b1; beA = 2'b11; addA = 4'd9; dinA = 16'hAAAA;
    enB = 1'b1; wrB = 1'b1; beB = 2'b11; addB = 4'd9; dinB = 16'h5555;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_cnt_fffe", {16'd0, cnt0}, 32'h0000FFFE);
    chk("sat_coll_high", {31'd0, col0}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_cnt_ffff", {16'd0, cnt0}, 32'h0000FFFF);
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    chk("sat_hold", {15'd0, col0, cnt0}, {15'd0, 1'b0, 16'hFFFF});
    chk("sat_hold_d2", {16'd0, cnt2}, 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
